instr_stream_decoder: RTL and testbench
=======================================

INSTR_STREAM_DECODER -- requirements
Module: instr_stream_decoder

Interface
REQ-001 SHALL have parameter NUM_OPS, default 16, number of opcodes; power of two, 2..256.
REQ-002 SHALL have parameter ADDR_W, default 16, operand width; multiple of 8, 8..32.
REQ-003 SHALL have parameter OPND_MASK [NUM_OPS-1:0], default 16'h00E6, bit i set = opcode i carries an address operand (LDAC, STAC, JUMP, JMPZ, JPNZ).
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port flush, input, 1, synchronous discard of partial or pending instruction.
REQ-007 SHALL have port byte_valid, input, 1, instruction-stream byte present.
REQ-008 SHALL have port byte_data, input, 8, instruction-stream byte.
REQ-009 SHALL have port byte_ready, output, 1, byte accepted when byte_valid && byte_ready.
REQ-010 SHALL have port dec_valid, output, 1, decoded instruction present.
REQ-011 SHALL have port dec_ready, input, 1, consumer accepts when dec_valid && dec_ready.
REQ-012 SHALL have port dec_onehot, output, NUM_OPS, one-hot opcode; bit 0 = NOP.
REQ-013 SHALL have port dec_addr, output, ADDR_W, assembled operand.
REQ-014 SHALL have port dec_illegal, output, 1, opcode out of range.
REQ-015 SHALL have port err_count, output, 8, count of illegal opcodes.

Function
REQ-016 SHALL implement states S_OPC (await opcode), S_OPND (collect operand bytes), S_OUT (hold result).
REQ-017 SHALL treat an opcode byte as legal iff byte_data < NUM_OPS.
REQ-018 In S_OPC, byte_ready SHALL be 1, and an accepted legal opcode SHALL register its one-hot code.
REQ-019 From S_OPC, an accepted opcode SHALL go to S_OPND with byte counter 0 if its OPND_MASK bit is set, else to S_OUT.
REQ-020 An accepted illegal opcode SHALL go to S_OUT with dec_illegal=1, dec_onehot=0 and dec_addr=0, and SHALL take no operand bytes.
REQ-021 In S_OPND, byte_ready SHALL be 1, and the k-th accepted byte (k from 0) SHALL be written to dec_addr[8k+7:8k] (little-endian).
REQ-022 S_OPND SHALL go to S_OUT on accepting byte ADDR_W/8-1.
REQ-023 Non-operand opcodes SHALL present dec_addr=0.
REQ-024 In S_OUT, dec_valid SHALL be 1 and dec_onehot, dec_addr and dec_illegal SHALL stay stable until the handshake.
REQ-025 In S_OUT, byte_ready SHALL equal dec_ready (combinational).
REQ-026 On an output handshake, a byte accepted in the same cycle SHALL be decoded as a new opcode per REQ-018/019; with no byte, the state SHALL return to S_OPC.
REQ-027 Latency SHALL be: opcode accepted at edge N gives dec_valid at cycle N+1 (no operand), or 1 cycle after the last operand byte is accepted.
REQ-028 Sustained throughput for non-operand opcodes SHALL be 1 instruction/cycle.
REQ-029 dec_valid SHALL be 0 outside S_OUT, and dec_onehot SHALL be zero or one-hot at all times.
REQ-030 flush SHALL override all other inputs: byte_ready=0 that cycle, next state S_OPC, dec_valid=0, dec_onehot, dec_addr and dec_illegal cleared, byte counter cleared.
REQ-031 A pending S_OUT result SHALL be discarded by flush, even if dec_ready=1 in that cycle.
REQ-032 err_count SHALL increment on each accepted illegal opcode and saturate at 255; flush SHALL NOT clear it.
REQ-033 byte_data SHALL be ignored when byte_valid=0, and the state SHALL NOT change without a handshake, flush or reset.

Reset
REQ-034 While reset=1, the block SHALL immediately force state S_OPC, byte counter 0, dec_valid=0, dec_onehot=0, dec_addr=0, dec_illegal=0, err_count=0.
REQ-035 Reset asserted mid-operand or mid-S_OUT SHALL abandon the instruction, with no output handshake and no error counted.
REQ-036 byte_ready SHALL be 0 while reset=1, and SHALL be 1 in the first cycle after release.

Structure
REQ-037 A shared package SHALL hold: the state typedef, an opcode enum (NOP=0, LDAC, STAC, MVAC, MOVR, JUMP, JMPZ, JPNZ, ADD, SUB, INAC, CLAC, AND, OR, XOR, NOT=15), the default NUM_OPS, the default OPND_MASK, and the ADDR_BYTES derivation.
REQ-038 The combinational byte-to-one-hot-plus-legal decode SHALL be a sub-module, opcode_onehot_dec, parametrised by NUM_OPS; all registers SHALL stay in instr_stream_decoder.

Verification
REQ-039 Stream 0x0A, dec_ready=1 -> next cycle dec_valid=1, dec_onehot=16'h0400, dec_addr=0, dec_illegal=0.
REQ-040 Stream 0x05,0x34,0x12 -> dec_onehot=16'h0020, dec_addr=16'h1234; dec_valid=0 until 1 cycle after 0x12 is accepted.
REQ-041 Stream 0x00,0x08,0x0F back-to-back, dec_ready=1 -> three consecutive dec_valid cycles, no byte_ready bubble.
REQ-042 Opcode 0x80, then 0x01 -> dec_illegal=1, dec_onehot=0, err_count=1; 0x01 then waits for its 2 operand bytes; 300 illegal opcodes -> err_count=255.
REQ-043 0x06,0x34 then flush -> no dec_valid, next 0x00 decodes as NOP; dec_ready held 0 for 5 cycles in S_OUT -> outputs stable, byte_ready=0.
REQ-044 Reset pulsed after 0x01,0x34, then 0x03 -> only MVAC (16'h0008) emitted, err_count=0.

Source files
------------

// File: rtl/instr_stream_decoder_pkg.sv
// Shared types, opcode map and default parameters for the instruction stream decoder.
package instr_stream_decoder_pkg;

    typedef enum logic [1:0] {
        S_OPC  = 2'd0,
        S_OPND = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    typedef enum logic [7:0] {
        OP_NOP  = 8'd0,
        OP_LDAC = 8'd1,
        OP_STAC = 8'd2,
        OP_MVAC = 8'd3,
        OP_MOVR = 8'd4,
        OP_JUMP = 8'd5,
        OP_JMPZ = 8'd6,
        OP_JPNZ = 8'd7,
        OP_ADD  = 8'd8,
        OP_SUB  = 8'd9,
        OP_INAC = 8'd10,
        OP_CLAC = 8'd11,
        OP_AND  = 8'd12,
        OP_OR   = 8'd13,
        OP_XOR  = 8'd14,
        OP_NOT  = 8'd15
    } opcode_t;

    localparam int unsigned DEF_NUM_OPS   = 16;
    localparam int unsigned DEF_ADDR_W    = 16;
    // LDAC, STAC, JUMP, JMPZ and JPNZ carry an address operand
    localparam logic [15:0] DEF_OPND_MASK = 16'h00E6;

    function automatic int unsigned addr_bytes(input int unsigned addr_w);
        return addr_w / 8;
    endfunction

endpackage

// File: rtl/opcode_onehot_dec.sv
// Combinational opcode byte to one-hot code plus legality flag.
module opcode_onehot_dec #(
    parameter int unsigned NUM_OPS = 16
) (
    input  logic [7:0]         byte_data,
    output logic [NUM_OPS-1:0] onehot_c,
    output logic               legal_c
);

    always_comb begin
        legal_c  = ({1'b0, byte_data} < 9'(NUM_OPS));
        onehot_c = legal_c ? (NUM_OPS'(1) << byte_data) : '0;
    end

endmodule

// File: rtl/instr_stream_decoder.sv
// Byte-stream instruction decoder: opcode byte plus optional little-endian operand,
// presented as a one-hot opcode with a valid/ready handshake.
module instr_stream_decoder
    import instr_stream_decoder_pkg::*;
#(
    parameter int unsigned         NUM_OPS   = DEF_NUM_OPS,
    parameter int unsigned         ADDR_W    = DEF_ADDR_W,
    parameter logic [NUM_OPS-1:0]  OPND_MASK = NUM_OPS'(DEF_OPND_MASK)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [NUM_OPS-1:0] dec_onehot,
    output logic [ADDR_W-1:0]  dec_addr,
    output logic               dec_illegal,
    output logic [7:0]         err_count
);

    localparam int unsigned ADDR_BYTES = addr_bytes(ADDR_W);
    localparam int unsigned CNT_W      = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;

    state_t               state, state_d;
    logic [CNT_W-1:0]     cnt, cnt_d;
    logic [NUM_OPS-1:0]   onehot_d;
    logic [ADDR_W-1:0]    addr_d;
    logic                 illegal_d;
    logic                 valid_d;
    logic [7:0]           err_d;

    logic [NUM_OPS-1:0]   op_onehot_c;
    logic                 op_legal_c;
    logic                 byte_hs_c;
    logic                 take_opc_c;

    opcode_onehot_dec #(
        .NUM_OPS (NUM_OPS)
    ) u_dec (
        .byte_data (byte_data),
        .onehot_c  (op_onehot_c),
        .legal_c   (op_legal_c)
    );

    // Ready follows the consumer while a result is held; flush and reset block intake
    always_comb begin
        byte_ready = 1'b0;
        if (!reset && !flush) begin
            byte_ready = (state == S_OUT) ? dec_ready : 1'b1;
        end
    end

    assign byte_hs_c = byte_valid && byte_ready;

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        onehot_d   = dec_onehot;
        addr_d     = dec_addr;
        illegal_d  = dec_illegal;
        valid_d    = dec_valid;
        err_d      = err_count;
        take_opc_c = 1'b0;

        if (flush) begin
            state_d   = S_OPC;
            cnt_d     = '0;
            onehot_d  = '0;
            addr_d    = '0;
            illegal_d = 1'b0;
            valid_d   = 1'b0;
        end else begin
            case (state)
                S_OPC: take_opc_c = byte_hs_c;
                S_OPND: begin
                    if (byte_hs_c) begin
                        addr_d[8*int'(cnt) +: 8] = byte_data;
                        if (cnt == CNT_W'(ADDR_BYTES - 1)) begin
                            state_d = S_OUT;
                            valid_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt + CNT_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    // Output handshake; a byte arriving alongside starts the next instruction
                    if (dec_ready) begin
                        if (byte_valid) begin
                            take_opc_c = 1'b1;
                        end else begin
                            state_d = S_OPC;
                            valid_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = S_OPC;
                    valid_d = 1'b0;
                end
            endcase

            if (take_opc_c) begin
                onehot_d  = op_legal_c ? op_onehot_c : '0;
                illegal_d = !op_legal_c;
                addr_d    = '0;
                cnt_d     = '0;
                if (!op_legal_c) begin
                    state_d = S_OUT;
                    valid_d = 1'b1;
                    if (err_count != 8'hFF) begin
                        err_d = err_count + 8'd1;
                    end
                end else if (|(OPND_MASK & op_onehot_c)) begin
                    state_d = S_OPND;
                    valid_d = 1'b0;
                end else begin
                    state_d = S_OUT;
                    valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_OPC;
            cnt         <= '0;
            dec_onehot  <= '0;
            dec_addr    <= '0;
            dec_illegal <= 1'b0;
            dec_valid   <= 1'b0;
            err_count   <= 8'd0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            dec_onehot  <= onehot_d;
            dec_addr    <= addr_d;
            dec_illegal <= illegal_d;
            dec_valid   <= valid_d;
            err_count   <= err_d;
        end
    end

endmodule

// File: tb/tb_instr_stream_decoder.sv
// Directed self-checking bench for instr_stream_decoder with default parameters.
module tb_instr_stream_decoder;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        dec_valid;
    logic        dec_ready;
    logic [15:0] dec_onehot;
    logic [15:0] dec_addr;
    logic        dec_illegal;
    logic [7:0]  err_count;

    int checks = 0;
    int errors = 0;

    instr_stream_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_onehot  (dec_onehot),
        .dec_addr    (dec_addr),
        .dec_illegal (dec_illegal),
        .err_count   (err_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past the next rising edge; inputs are then driven and outputs sampled mid-cycle
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        byte_valid = v;
        byte_data  = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cycle();
        cycle();
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", byte_ready); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dec_valid); end
        checks++; if (dec_onehot !== 16'h0000) begin errors++; $display("FAIL reset_onehot: got %h want 0000", dec_onehot); end
        checks++; if (dec_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h want 0000", dec_addr); end
        checks++; if (dec_illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", dec_illegal); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
        reset = 1'b0;
        #1;
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", byte_ready); end
    endtask

    task automatic test_single();
        dec_ready = 1'b1;
        drive(1'b1, 8'h0A);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b want 1", byte_ready); end
        cycle();
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", dec_valid); end
        checks++; if (dec_onehot !== 16'h0400) begin errors++; $display("FAIL single_onehot: got %h want 0400", dec_onehot); end
        checks++; if (dec_addr !== 16'h0000) begin errors++; $display("FAIL single_addr: got %h want 0000", dec_addr); end
        checks++; if (dec_illegal !== 1'b0) begin errors++; $display("FAIL single_illegal: got %b want 0", dec_illegal); end
        cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL single_done: got %b want 0", dec_valid); end
    endtask

    task automatic test_operand();
        dec_ready = 1'b1;
        drive(1'b1, 8'h05);
        cycle();
        drive(1'b1, 8'h34);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL opnd_wait0: got %b want 0", dec_valid); end
        cycle();
        drive(1'b1, 8'h12);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL opnd_wait1: got %b want 0", dec_valid); end
        cycle();
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL opnd_valid: got %b want 1", dec_valid); end
        checks++; if (dec_onehot !== 16'h0020) begin errors++; $display("FAIL opnd_onehot: got %h want 0020", dec_onehot); end
        checks++; if (dec_addr !== 16'h1234) begin errors++; $display("FAIL opnd_addr: got %h want 1234", dec_addr); end
        cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL opnd_done: got %b want 0", dec_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ops [3];
        logic [15:0] exp [3];
        ops[0] = 8'h00; ops[1] = 8'h08; ops[2] = 8'h0F;
        exp[0] = 16'h0001; exp[1] = 16'h0100; exp[2] = 16'h8000;
        dec_ready = 1'b1;
        drive(1'b1, ops[0]);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready0: got %b want 1", byte_ready); end
        cycle();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) drive(1'b1, ops[i+1]);
            else       drive(1'b0, 8'h00);
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid%0d: got %b want 1", i, dec_valid); end
            checks++; if (dec_onehot !== exp[i]) begin errors++; $display("FAIL b2b_onehot%0d: got %h want %h", i, dec_onehot, exp[i]); end
            checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b want 1", i + 1, byte_ready); end
            cycle();
        end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL b2b_done: got %b want 0", dec_valid); end
    endtask

    task automatic test_illegal();
        dec_ready = 1'b1;
        drive(1'b1, 8'h80);
        cycle();
        drive(1'b1, 8'h01);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL ill_valid: got %b want 1", dec_valid); end
        checks++; if (dec_illegal !== 1'b1) begin errors++; $display("FAIL ill_flag: got %b want 1", dec_illegal); end
        checks++; if (dec_onehot !== 16'h0000) begin errors++; $display("FAIL ill_onehot: got %h want 0000", dec_onehot); end
        checks++; if (dec_addr !== 16'h0000) begin errors++; $display("FAIL ill_addr: got %h want 0000", dec_addr); end
        checks++; if (err_count !== 8'd1) begin errors++; $display("FAIL ill_err1: got %0d want 1", err_count); end
        cycle();
        drive(1'b1, 8'hCD);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL ldac_wait0: got %b want 0", dec_valid); end
        cycle();
        drive(1'b1, 8'hAB);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL ldac_wait1: got %b want 0", dec_valid); end
        cycle();
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL ldac_valid: got %b want 1", dec_valid); end
        checks++; if (dec_onehot !== 16'h0002) begin errors++; $display("FAIL ldac_onehot: got %h want 0002", dec_onehot); end
        checks++; if (dec_addr !== 16'hABCD) begin errors++; $display("FAIL ldac_addr: got %h want abcd", dec_addr); end
        checks++; if (dec_illegal !== 1'b0) begin errors++; $display("FAIL ldac_illegal: got %b want 0", dec_illegal); end
        cycle();
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'hFF);
            cycle();
            if (i == 99) begin
                checks++; if (err_count !== 8'd101) begin errors++; $display("FAIL err_mid: got %0d want 101", err_count); end
            end
        end
        drive(1'b0, 8'h00);
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL err_sat: got %0d want 255", err_count); end
        checks++; if (dec_illegal !== 1'b1) begin errors++; $display("FAIL err_sat_flag: got %b want 1", dec_illegal); end
        cycle();
    endtask

    task automatic test_flush();
        dec_ready = 1'b1;
        drive(1'b1, 8'h06);
        cycle();
        drive(1'b1, 8'h34);
        cycle();
        flush = 1'b1;
        drive(1'b1, 8'h12);
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", byte_ready); end
        cycle();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", dec_valid); end
        checks++; if (dec_onehot !== 16'h0000) begin errors++; $display("FAIL flush_onehot: got %h want 0000", dec_onehot); end
        checks++; if (dec_addr !== 16'h0000) begin errors++; $display("FAIL flush_addr: got %h want 0000", dec_addr); end
        checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL flush_err: got %0d want 255", err_count); end
        cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL flush_idle: got %b want 0", dec_valid); end
        drive(1'b1, 8'h00);
        cycle();
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL postflush_valid: got %b want 1", dec_valid); end
        checks++; if (dec_onehot !== 16'h0001) begin errors++; $display("FAIL postflush_onehot: got %h want 0001", dec_onehot); end
        cycle();
        // Stall in the output state, then flush while the consumer is ready
        dec_ready = 1'b0;
        drive(1'b1, 8'h0D);
        cycle();
        drive(1'b1, 8'h0E);
        for (int i = 0; i < 5; i++) begin
            checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL stall_valid%0d: got %b want 1", i, dec_valid); end
            checks++; if (dec_onehot !== 16'h2000) begin errors++; $display("FAIL stall_onehot%0d: got %h want 2000", i, dec_onehot); end
            checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b want 0", i, byte_ready); end
            cycle();
        end
        flush = 1'b1;
        dec_ready = 1'b1;
        #1;
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL stall_flush_ready: got %b want 0", byte_ready); end
        cycle();
        flush = 1'b0;
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL stall_flush_valid: got %b want 0", dec_valid); end
        checks++; if (dec_onehot !== 16'h0000) begin errors++; $display("FAIL stall_flush_onehot: got %h want 0000", dec_onehot); end
        cycle();
    endtask

    task automatic test_reset_mid();
        dec_ready = 1'b1;
        drive(1'b1, 8'h01);
        cycle();
        drive(1'b1, 8'h34);
        cycle();
        reset = 1'b1;
        drive(1'b0, 8'h00);
        checks++; if (byte_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b want 0", byte_ready); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_err: got %0d want 0", err_count); end
        checks++; if (dec_addr !== 16'h0000) begin errors++; $display("FAIL rmid_addr: got %h want 0000", dec_addr); end
        cycle();
        reset = 1'b0;
        drive(1'b1, 8'h03);
        checks++; if (byte_ready !== 1'b1) begin errors++; $display("FAIL rmid_release: got %b want 1", byte_ready); end
        cycle();
        drive(1'b0, 8'h00);
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL rmid_valid: got %b want 1", dec_valid); end
        checks++; if (dec_onehot !== 16'h0008) begin errors++; $display("FAIL rmid_onehot: got %h want 0008", dec_onehot); end
        checks++; if (dec_addr !== 16'h0000) begin errors++; $display("FAIL rmid_addr_out: got %h want 0000", dec_addr); end
        checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rmid_err_out: got %0d want 0", err_count); end
        cycle();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rmid_done: got %b want 0", dec_valid); end
    endtask

    initial begin
        reset      = 1'b0;
        flush      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        dec_ready  = 1'b0;
        #2;
        test_reset();
        test_single();
        test_operand();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
